// File: rtl/score_digit_video.sv
// score_digit_video: renders two 2-digit seven-segment scores into the video
// stream. BCD digits are latched once per frame at the vblank rising edge;
// the pixel output follows hpos/vpos with a fixed two-register latency.
module score_digit_video #(
    parameter logic [8:0] P1_X      = 9'd160,
    parameter logic [8:0] P2_X      = 9'd288,
    parameter logic [8:0] Y_TOP     = 9'd16,
    parameter int         DIGIT_W   = 16,
    parameter int         DIGIT_H   = 32,
    parameter int         SEG_W     = 4,
    parameter int         DIGIT_GAP = 8
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       vblank,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic [3:0] p1_tens,
    input  logic [3:0] p1_units,
    input  logic [3:0] p2_tens,
    input  logic [3:0] p2_units,
    output logic       score_video
);

    localparam int XW = $clog2(DIGIT_W);
    localparam int YW = $clog2(DIGIT_H);

    // Box geometry in 10 bits so right edges near column 511 cannot wrap.
    localparam logic [9:0] W10   = 10'(DIGIT_W);
    localparam logic [9:0] H10   = 10'(DIGIT_H);
    localparam logic [9:0] GAP10 = 10'(DIGIT_GAP);
    localparam logic [9:0] Y10   = {1'b0, Y_TOP};
    localparam logic [9:0] L_P1T = {1'b0, P1_X};
    localparam logic [9:0] L_P1U = L_P1T + W10 + GAP10;
    localparam logic [9:0] L_P2T = {1'b0, P2_X};
    localparam logic [9:0] L_P2U = L_P2T + W10 + GAP10;

    // Segment band boundaries in box-local coordinates.
    localparam logic [YW-1:0] Y_A_END = YW'(SEG_W);
    localparam logic [YW-1:0] Y_D_BEG = YW'(DIGIT_H - SEG_W);
    localparam logic [YW-1:0] Y_H2    = YW'(DIGIT_H / 2);
    localparam logic [YW-1:0] Y_G_BEG = YW'(DIGIT_H / 2 - SEG_W / 2);
    localparam logic [YW-1:0] Y_G_END = YW'(DIGIT_H / 2 + SEG_W / 2);
    localparam logic [XW-1:0] X_L_END = XW'(SEG_W);
    localparam logic [XW-1:0] X_R_BEG = XW'(DIGIT_W - SEG_W);

    // Digit select codes: bit 0 clear means a tens digit (subject to blanking).
    localparam logic [1:0] SEL_P1T = 2'd0;
    localparam logic [1:0] SEL_P1U = 2'd1;
    localparam logic [1:0] SEL_P2T = 2'd2;
    localparam logic [1:0] SEL_P2U = 2'd3;

    function automatic logic in_box(input logic [9:0] h, input logic [9:0] left);
        return (h >= left) && (h < left + W10);
    endfunction

    // Lit segments as {a,b,c,d,e,f,g}; non-decimal codes are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Segments whose region covers local (x, y), same {a..g} ordering.
    function automatic logic [6:0] seg_region(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [6:0] r;
        r[6] = (y < Y_A_END);
        r[5] = (x >= X_R_BEG) && (y < Y_H2);
        r[4] = (x >= X_R_BEG) && (y >= Y_H2);
        r[3] = (y >= Y_D_BEG);
        r[2] = (x < X_L_END) && (y >= Y_H2);
        r[1] = (x < X_L_END) && (y < Y_H2);
        r[0] = (y >= Y_G_BEG) && (y < Y_G_END);
        return r;
    endfunction

    logic          r_vblank_q;
    logic [3:0]    r_p1_tens, r_p1_units, r_p2_tens, r_p2_units;
    logic          r_hit_p1;
    logic [1:0]    r_sel_p1;
    logic [XW-1:0] r_x_p1;
    logic [YW-1:0] r_y_p1;
    logic          r_video_p2;

    logic [9:0]    w_h10, w_v10;
    logic          w_in_y;
    logic          w_hit;
    logic [1:0]    w_sel;
    logic [XW-1:0] w_dx;
    logic [YW-1:0] w_dy;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic          w_lit;
    logic          w_capture;

    assign w_h10     = {1'b0, hpos};
    assign w_v10     = {1'b0, vpos};
    assign w_in_y    = (w_v10 >= Y10) && (w_v10 < Y10 + H10);
    assign w_dy      = YW'(w_v10 - Y10);
    assign w_capture = vblank && !r_vblank_q;

    // Edge detector and once-per-frame digit latches.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_vblank_q <= 1'b0;
            r_p1_tens  <= 4'd0;
            r_p1_units <= 4'd0;
            r_p2_tens  <= 4'd0;
            r_p2_units <= 4'd0;
        end else begin
            r_vblank_q <= vblank;
            if (w_capture) begin
                r_p1_tens  <= p1_tens;
                r_p1_units <= p1_units;
                r_p2_tens  <= p2_tens;
                r_p2_units <= p2_units;
            end
        end
    end

    // Box hit detection and local x offset for the current raster position.
    always_comb begin
        w_hit = 1'b0;
        w_sel = SEL_P1T;
        w_dx  = '0;
        if (w_in_y) begin
            if (in_box(w_h10, L_P1T)) begin
                w_hit = 1'b1;
                w_sel = SEL_P1T;
                w_dx  = XW'(w_h10 - L_P1T);
            end else if (in_box(w_h10, L_P1U)) begin
                w_hit = 1'b1;
                w_sel = SEL_P1U;
                w_dx  = XW'(w_h10 - L_P1U);
            end else if (in_box(w_h10, L_P2T)) begin
                w_hit = 1'b1;
                w_sel = SEL_P2T;
                w_dx  = XW'(w_h10 - L_P2T);
            end else if (in_box(w_h10, L_P2U)) begin
                w_hit = 1'b1;
                w_sel = SEL_P2U;
                w_dx  = XW'(w_h10 - L_P2U);
            end
        end
    end

    // Stage 1: register hit, digit select and local coordinates.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_hit_p1 <= 1'b0;
            r_sel_p1 <= SEL_P1T;
            r_x_p1   <= '0;
            r_y_p1   <= '0;
        end else begin
            r_hit_p1 <= w_hit;
            r_sel_p1 <= w_sel;
            r_x_p1   <= w_dx;
            r_y_p1   <= w_dy;
        end
    end

    // Digit selection, leading-zero blanking and segment lookup.
    always_comb begin
        w_digit = 4'd0;
        case (r_sel_p1)
            SEL_P1T: w_digit = r_p1_tens;
            SEL_P1U: w_digit = r_p1_units;
            SEL_P2T: w_digit = r_p2_tens;
            default: w_digit = r_p2_units;
        endcase
        w_blank = !r_sel_p1[0] && (w_digit == 4'd0);
        w_lit   = r_hit_p1 && !w_blank &&
                  (|(seg_decode(w_digit) & seg_region(r_x_p1, r_y_p1)));
    end

    // Stage 2: register the final score pixel.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_video_p2 <= 1'b0;
        end else begin
            r_video_p2 <= w_lit;
        end
    end

    assign score_video = r_video_p2;

endmodule

// File: tb/tb_score_digit_video.sv
// Directed bench for score_digit_video using the default geometry:
// boxes P1T 160..175, P1U 184..199, P2T 288..303, P2U 312..327, rows 16..47.
module tb_score_digit_video;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vblank;
    logic [8:0] hpos, vpos;
    logic [3:0] p1_tens, p1_units, p2_tens, p2_units;
    logic       score_video;

    int checks = 0;
    int errors = 0;

    score_digit_video dut (
        .clk        (clk),
        ._reset     (reset_n),
        .vblank     (vblank),
        .hpos       (hpos),
        .vpos       (vpos),
        .p1_tens    (p1_tens),
        .p1_units   (p1_units),
        .p2_tens    (p2_tens),
        .p2_units   (p2_units),
        .score_video(score_video)
    );

    always #5 clk = ~clk;

    // Present a position and read the pixel two clock edges later.
    task automatic sample(input logic [8:0] h, input logic [8:0] v, output logic val);
        @(posedge clk); #1;
        hpos = h;
        vpos = v;
        @(posedge clk);
        @(posedge clk); #1;
        val = score_video;
    endtask

    // Drive digits and pulse vblank for a few clocks with the raster off-box.
    task automatic latch(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        @(posedge clk); #1;
        p1_tens = a; p1_units = b; p2_tens = c; p2_units = d;
        hpos = 9'd0; vpos = 9'd0;
        vblank = 1'b1;
        repeat (4) @(posedge clk);
        #1 vblank = 1'b0;
    endtask

    task automatic test_reset();
        logic got;
        logic [18:0] t [4] = '{{9'd184, 9'd16, 1'b1}, {9'd160, 9'd16, 1'b0},
                               {9'd192, 9'd32, 1'b0}, {9'd199, 9'd40, 1'b1}};
        reset_n = 1'b1; vblank = 1'b0;
        p1_tens = 4'd5; p1_units = 4'd5; p2_tens = 4'd5; p2_units = 4'd5;
        hpos = 9'd184; vpos = 9'd16;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (score_video !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got %b want 0", score_video);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(t[i][18:10], t[i][9:1], got);
            checks++;
            if (got !== t[i][0]) begin
                errors++;
                $display("FAIL reset_zero[%0d] h=%0d v=%0d got %b want %b",
                         i, t[i][18:10], t[i][9:1], got, t[i][0]);
            end
        end
    endtask

    task automatic test_latency();
        logic got;
        logic [18:0] t [7] = '{{9'd192, 9'd20, 1'b0}, {9'd176, 9'd16, 1'b0},
                               {9'd183, 9'd16, 1'b0}, {9'd184, 9'd15, 1'b0},
                               {9'd184, 9'd48, 1'b0}, {9'd159, 9'd16, 1'b0},
                               {9'd175, 9'd16, 1'b1}};
        latch(4'd8, 4'd8, 4'd0, 4'd0);
        @(posedge clk); #1;
        hpos = 9'd250; vpos = 9'd30;
        repeat (2) @(posedge clk); #1;
        hpos = 9'd184; vpos = 9'd16;
        @(posedge clk); #1;
        checks++;
        if (score_video !== 1'b0) begin
            errors++;
            $display("FAIL latency_1clk got %b want 0", score_video);
        end
        @(posedge clk); #1;
        checks++;
        if (score_video !== 1'b1) begin
            errors++;
            $display("FAIL latency_2clk got %b want 1", score_video);
        end
        for (int i = 0; i < 7; i++) begin
            sample(t[i][18:10], t[i][9:1], got);
            checks++;
            if (got !== t[i][0]) begin
                errors++;
                $display("FAIL geom[%0d] h=%0d v=%0d got %b want %b",
                         i, t[i][18:10], t[i][9:1], got, t[i][0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic got;
        logic [18:0] t [3] = '{{9'd175, 9'd16, 1'b0}, {9'd184, 9'd16, 1'b1},
                               {9'd192, 9'd32, 1'b0}};
        sample(9'd184, 9'd16, got);
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got %b want 1", got);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (score_video !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got %b want 0", score_video);
        end
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample(t[i][18:10], t[i][9:1], got);
            checks++;
            if (got !== t[i][0]) begin
                errors++;
                $display("FAIL post_reset[%0d] h=%0d v=%0d got %b want %b",
                         i, t[i][18:10], t[i][9:1], got, t[i][0]);
            end
        end
        // Reset released while vblank is already high must capture at once.
        @(posedge clk); #1;
        reset_n = 1'b0;
        vblank = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sample(9'd192, 9'd32, got);
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL reset_vblank_capture got %b want 1", got);
        end
        vblank = 1'b0;
    endtask

    task automatic test_leading_zero();
        logic got;
        logic [18:0] t [6] = '{{9'd160, 9'd16, 1'b0}, {9'd160, 9'd40, 1'b0},
                               {9'd175, 9'd20, 1'b0}, {9'd190, 9'd16, 1'b1},
                               {9'd184, 9'd20, 1'b0}, {9'd199, 9'd20, 1'b1}};
        latch(4'd0, 4'd7, 4'd0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            sample(t[i][18:10], t[i][9:1], got);
            checks++;
            if (got !== t[i][0]) begin
                errors++;
                $display("FAIL lead_zero[%0d] h=%0d v=%0d got %b want %b",
                         i, t[i][18:10], t[i][9:1], got, t[i][0]);
            end
        end
    endtask

    task automatic test_latch_timing();
        logic got;
        logic [18:0] t42 [3] = '{{9'd288, 9'd20, 1'b1}, {9'd312, 9'd40, 1'b1},
                                 {9'd327, 9'd40, 1'b0}};
        logic [18:0] t43 [3] = '{{9'd288, 9'd20, 1'b1}, {9'd312, 9'd40, 1'b0},
                                 {9'd327, 9'd40, 1'b1}};
        latch(4'd0, 4'd0, 4'd4, 4'd2);
        for (int i = 0; i < 3; i++) begin
            sample(t42[i][18:10], t42[i][9:1], got);
            checks++;
            if (got !== t42[i][0]) begin
                errors++;
                $display("FAIL show42[%0d] got %b want %b", i, got, t42[i][0]);
            end
        end
        p2_units = 4'd3;
        for (int i = 0; i < 3; i++) begin
            sample(t42[i][18:10], t42[i][9:1], got);
            checks++;
            if (got !== t42[i][0]) begin
                errors++;
                $display("FAIL hold42[%0d] got %b want %b", i, got, t42[i][0]);
            end
        end
        latch(4'd0, 4'd0, 4'd4, 4'd3);
        for (int i = 0; i < 3; i++) begin
            sample(t43[i][18:10], t43[i][9:1], got);
            checks++;
            if (got !== t43[i][0]) begin
                errors++;
                $display("FAIL show43[%0d] got %b want %b", i, got, t43[i][0]);
            end
        end
    endtask

    task automatic test_invalid();
        logic got;
        logic [18:0] t [9] = '{{9'd312, 9'd16, 1'b0}, {9'd312, 9'd20, 1'b0},
                               {9'd327, 9'd20, 1'b0}, {9'd320, 9'd32, 1'b0},
                               {9'd327, 9'd40, 1'b0}, {9'd303, 9'd20, 1'b1},
                               {9'd303, 9'd40, 1'b1}, {9'd296, 9'd16, 1'b0},
                               {9'd290, 9'd16, 1'b0}};
        latch(4'd0, 4'd0, 4'd1, 4'd12);
        for (int i = 0; i < 9; i++) begin
            sample(t[i][18:10], t[i][9:1], got);
            checks++;
            if (got !== t[i][0]) begin
                errors++;
                $display("FAIL invalid[%0d] h=%0d v=%0d got %b want %b",
                         i, t[i][18:10], t[i][9:1], got, t[i][0]);
            end
        end
    endtask

    task automatic test_rollover();
        logic got;
        logic [18:0] t10 [4] = '{{9'd175, 9'd20, 1'b1}, {9'd184, 9'd20, 1'b1},
                                 {9'd192, 9'd32, 1'b0}, {9'd160, 9'd20, 1'b0}};
        logic [18:0] t9 [6]  = '{{9'd175, 9'd20, 1'b0}, {9'd170, 9'd16, 1'b0},
                                 {9'd192, 9'd32, 1'b1}, {9'd184, 9'd40, 1'b0},
                                 {9'd199, 9'd20, 1'b1}, {9'd199, 9'd40, 1'b1}};
        latch(4'd1, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            sample(t10[i][18:10], t10[i][9:1], got);
            checks++;
            if (got !== t10[i][0]) begin
                errors++;
                $display("FAIL frame10[%0d] got %b want %b", i, got, t10[i][0]);
            end
        end
        // Long vblank: inputs changing while it stays high must not recapture.
        @(posedge clk); #1;
        p1_tens = 4'd0; p1_units = 4'd9;
        hpos = 9'd0; vpos = 9'd0;
        vblank = 1'b1;
        repeat (2) @(posedge clk); #1;
        p1_units = 4'd5;
        repeat (5) @(posedge clk); #1;
        vblank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample(t9[i][18:10], t9[i][9:1], got);
            checks++;
            if (got !== t9[i][0]) begin
                errors++;
                $display("FAIL frame9[%0d] got %b want %b", i, got, t9[i][0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_reset_mid();
        test_leading_zero();
        test_latch_timing();
        test_invalid();
        test_rollover();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
